instr_fetch_unit: RTL and testbench

- Instruction-side responder for the core control unit: holds the program counter and the on-chip instruction RAM (IRAM), and returns instruction bytes when the control unit asserts read_IRAM.
- Drives the status (run-enable) input of the control unit.
- Consumes the control unit's PC-increment, jump-load and end_process outputs, and reports done to the host.
- One instance per core; the host loads the program through a write port before start.

---
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch unit bus: host program/start signals and the
// control-unit fetch/PC handshake, grouped for a single port.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 8
);
  // host side
  logic               start;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               done;
  logic               wrap_err;
  // control-unit side
  logic               read_IRAM;
  logic               pc_inc;
  logic               pc_load;
  logic [ADDR_W-1:0]  load_addr;
  logic               end_process;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               status;
  logic [ADDR_W-1:0]  pc;

  modport master (
    output start, prog_we, prog_addr, prog_data,
    output read_IRAM, pc_inc, pc_load, load_addr, end_process,
    input  instruction, instr_valid, status, pc, done, wrap_err
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    input  read_IRAM, pc_inc, pc_load, load_addr, end_process,
    output instruction, instr_valid, status, pc, done, wrap_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, instruction RAM and the
// IDLE/RUN/HALT sequencer that gates the control unit's run enable.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned DEPTH   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               wrap_q, wrap_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic               in_run;
  logic               prog_ok;
  logic [ADDR_W:0]    load_ext;
  logic [ADDR_W:0]    load_mod;

  assign in_run   = (state_q == RUN);
  assign prog_ok  = bus.prog_we && !in_run && ({1'b0, bus.prog_addr} < DEPTH_W);
  assign load_ext = {1'b0, bus.load_addr};
  assign load_mod = load_ext % DEPTH_W;

  // Next state, PC, wrap flag and fetch register; read uses the pre-edge PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
          wrap_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.read_IRAM) begin
          instr_d = mem_q[pc_q];
          valid_d = 1'b1;
        end
        if (bus.pc_load) begin
          pc_d = load_mod[ADDR_W-1:0];
          if (load_ext >= DEPTH_W) wrap_d = 1'b1;
        end else if (bus.pc_inc) begin
          if (pc_q == LAST_PC) begin
            pc_d   = '0;
            wrap_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        if (bus.end_process) state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Instruction RAM host write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_ok) mem_q[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.status      = (state_q == RUN);
  assign bus.done        = (state_q == HALT);
  assign bus.pc          = pc_q;
  assign bus.wrap_err    = wrap_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: programming, fetch, jump priority,
// wrap, halt/restart and asynchronous reset.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;

  instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
    bus.read_IRAM   = 1'b0;
    bus.pc_inc      = 1'b0;
    bus.pc_load     = 1'b0;
    bus.load_addr   = '0;
    bus.end_process = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic jump(input logic [7:0] a);
    bus.pc_load = 1'b1; bus.load_addr = a;
    tick();
    bus.pc_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [4];
    prog[0] = 8'h04; prog[1] = 8'h08; prog[2] = 8'h0B; prog[3] = 8'h14;
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_status", bus.status, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_instr", bus.instruction, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_wrap", bus.wrap_err, 0);
    rst_n = 1'b1;
    tick();

    // 1: load program and fetch sequentially
    for (int i = 0; i < 4; i++) wr(8'(i), prog[i]);
    wr(8'h20, 8'h5A);
    // read/inc ignored in IDLE
    bus.read_IRAM = 1'b1; bus.pc_inc = 1'b1;
    tick();
    check("idle_pc", bus.pc, 0);
    check("idle_valid", bus.instr_valid, 0);
    bus.read_IRAM = 1'b0; bus.pc_inc = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_status", bus.status, 1);
    check("start_pc", bus.pc, 0);
    for (int i = 0; i < 4; i++) begin
      bus.read_IRAM = 1'b1; bus.pc_inc = 1'b1;
      tick();
      check("seq_instr", bus.instruction, 32'(prog[i]));
      check("seq_valid", bus.instr_valid, 1);
      check("seq_pc", bus.pc, 32'(i + 1));
    end
    bus.read_IRAM = 1'b0; bus.pc_inc = 1'b0;
    tick();
    check("hold_valid", bus.instr_valid, 0);
    check("hold_instr", bus.instruction, 32'h14);

    // 2: load beats increment
    bus.pc_inc = 1'b1;
    tick();
    check("pc5", bus.pc, 5);
    bus.pc_load = 1'b1; bus.load_addr = 8'h20;
    tick();
    bus.pc_load = 1'b0; bus.pc_inc = 1'b0;
    check("jump_pc", bus.pc, 32'h20);
    bus.read_IRAM = 1'b1;
    tick();
    bus.read_IRAM = 1'b0;
    check("jump_instr", bus.instruction, 32'h5A);
    check("jump_pc_hold", bus.pc, 32'h20);

    // 3: read and increment together
    jump(8'h02);
    bus.read_IRAM = 1'b1; bus.pc_inc = 1'b1;
    tick();
    bus.read_IRAM = 1'b0; bus.pc_inc = 1'b0;
    check("rdinc_instr", bus.instruction, 32'h0B);
    check("rdinc_pc", bus.pc, 3);

    // 4: wrap past DEPTH-1
    jump(8'hFF);
    check("prewrap_flag", bus.wrap_err, 0);
    bus.pc_inc = 1'b1;
    tick();
    bus.pc_inc = 1'b0;
    check("wrap_pc", bus.pc, 0);
    check("wrap_flag", bus.wrap_err, 1);
    for (int i = 0; i < 10; i++) tick();
    check("wrap_sticky", bus.wrap_err, 1);

    // 5: end with simultaneous read and increment
    jump(8'h03);
    bus.end_process = 1'b1; bus.read_IRAM = 1'b1; bus.pc_inc = 1'b1;
    tick();
    bus.end_process = 1'b0; bus.read_IRAM = 1'b0; bus.pc_inc = 1'b0;
    check("end_instr", bus.instruction, 32'h14);
    check("end_valid", bus.instr_valid, 1);
    check("end_status", bus.status, 0);
    check("end_done", bus.done, 1);
    check("end_pc", bus.pc, 4);
    bus.read_IRAM = 1'b1; bus.pc_inc = 1'b1;
    tick();
    bus.read_IRAM = 1'b0; bus.pc_inc = 1'b0;
    check("halt_pc", bus.pc, 4);
    check("halt_valid", bus.instr_valid, 0);
    check("halt_instr", bus.instruction, 32'h14);
    wr(8'h00, 8'h2B);
    bus.start = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = 8'h01; bus.prog_data = 8'h3C;
    tick();
    bus.start = 1'b0; bus.prog_we = 1'b0;
    check("restart_done", bus.done, 0);
    check("restart_status", bus.status, 1);
    check("restart_pc", bus.pc, 0);
    check("restart_wrap", bus.wrap_err, 0);
    bus.read_IRAM = 1'b1; bus.pc_inc = 1'b1;
    tick();
    check("reprog_instr0", bus.instruction, 32'h2B);
    tick();
    bus.read_IRAM = 1'b0; bus.pc_inc = 1'b0;
    check("samecyc_instr1", bus.instruction, 32'h3C);
    wr(8'h02, 8'hEE);
    jump(8'h02);
    bus.read_IRAM = 1'b1;
    tick();
    bus.read_IRAM = 1'b0;
    check("runwr_ignored", bus.instruction, 32'h0B);

    // 6: asynchronous reset mid-run
    jump(8'h07);
    check("pre_rst_pc", bus.pc, 7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_status", bus.status, 0);
    check("arst_pc", bus.pc, 0);
    check("arst_instr", bus.instruction, 0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_status", bus.status, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.read_IRAM = 1'b1;
    tick();
    bus.read_IRAM = 1'b0;
    check("retained_instr0", bus.instruction, 32'h2B);
    check("retained_valid", bus.instr_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
